// File: rtl/spike_pkg.sv
// Shared constants and types for the spiking-neuron blocks (neuron models and
// rate/interval decoders).
package spike_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Largest value a saturating counter of the given width may hold.
  function automatic int sat_limit(input int width);
    return (1 << width) - 1;
  endfunction

  localparam int SAT_LIMIT = sat_limit(CNT_W_DEFAULT);

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_LOAD,
    CNT_CLEAR
  } cnt_op_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear > load > increment priority; it sticks at the
// width's maximum instead of wrapping.
module sat_counter
  import spike_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = W'(sat_limit(W));

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  cnt_op_e      op;

  always_comb begin
    op      = CNT_HOLD;
    count_d = count_q;
    if (clear) begin
      op = CNT_CLEAR;
    end else if (load) begin
      op = CNT_LOAD;
    end else if (inc) begin
      op = CNT_INC;
    end
    unique case (op)
      CNT_CLEAR: count_d = '0;
      CNT_LOAD:  count_d = load_val;
      CNT_INC:   count_d = (count_q == MAX_VAL) ? count_q : count_q + W'(1);
      default:   count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a neuron spike line into a per-window rising-edge rate and the
// interval between the two most recent edges, both saturating.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             clear,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [CNT_W-1:0] isi_out,
  output logic             isi_valid
);

  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(sat_limit(CNT_W));

  logic                   spike_d_q, spike_d_d;
  logic                   seen_q, seen_d;
  logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]       rate_out_q, rate_out_d;
  logic                   rate_sat_q, rate_sat_d;
  logic                   rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0]       isi_out_q, isi_out_d;
  logic                   isi_valid_q, isi_valid_d;

  logic                   rise;
  logic                   rise_hit;
  logic                   terminal;
  logic [CNT_W-1:0]       window_total;
  logic [CNT_W-1:0]       spk_cnt;
  logic [CNT_W-1:0]       isi_cnt;

  // Counts edges in the open window; restarts as the closing window is reported.
  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear | terminal),
    .load     (1'b0),
    .inc      (rise_hit),
    .load_val ('0),
    .count    (spk_cnt)
  );

  // Cycles since the last edge; reloads to 1 on each edge.
  sat_counter #(.W(CNT_W)) u_isi_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (rise_hit),
    .inc      (1'b1),
    .load_val (CNT_W'(1)),
    .count    (isi_cnt)
  );

  always_comb begin
    spike_d_d    = spike_in;
    rise         = spike_in & ~spike_d_q;
    rise_hit     = rise & ~clear;
    terminal     = (&win_cnt_q) & ~clear;
    win_cnt_d    = clear ? '0 : win_cnt_q + WINDOW_LOG2'(1);
    seen_d       = clear ? 1'b0 : (seen_q | rise_hit);

    // An edge landing in the terminal cycle still belongs to the closing window.
    window_total = (rise_hit && spk_cnt != SAT_MAX) ? spk_cnt + CNT_W'(1) : spk_cnt;

    rate_out_d   = rate_out_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = terminal;
    if (terminal) begin
      rate_out_d = window_total;
      rate_sat_d = (window_total == SAT_MAX);
    end

    isi_out_d    = isi_out_q;
    isi_valid_d  = rise_hit & seen_q;
    if (rise_hit && seen_q) begin
      isi_out_d = isi_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_d_q    <= 1'b0;
      seen_q       <= 1'b0;
      win_cnt_q    <= '0;
      rate_out_q   <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_out_q    <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      spike_d_q    <= spike_d_d;
      seen_q       <= seen_d;
      win_cnt_q    <= win_cnt_d;
      rate_out_q   <= rate_out_d;
      rate_sat_q   <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      isi_out_q    <= isi_out_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign rate_out   = rate_out_q;
  assign rate_sat   = rate_sat_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_out_q;
  assign isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: dut_a uses a 16-cycle window, dut_b a 1024-cycle window for
// rate saturation. Expected outputs carry the cycle (from reset release) they must appear in.
module tb_spike_rate_decoder;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, spike_a, clear_a;
  logic       rst_b, spike_b, clear_b;
  logic [7:0] rate_out_a, isi_out_a, rate_out_b, isi_out_b;
  logic       rate_valid_a, rate_sat_a, isi_valid_a;
  logic       rate_valid_b, rate_sat_b, isi_valid_b;

  int   cyc = 0;
  int   t0  = 0;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t rate_qa[$], isi_qa[$], rate_qb[$], isi_qb[$];
  exp_t e_ra, e_ia, e_rb, e_ib;

  spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .spike_in(spike_a), .clear(clear_a),
    .rate_out(rate_out_a), .rate_valid(rate_valid_a), .rate_sat(rate_sat_a),
    .isi_out(isi_out_a), .isi_valid(isi_valid_a)
  );

  spike_rate_decoder #(.WINDOW_LOG2(10), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .spike_in(spike_b), .clear(clear_b),
    .rate_out(rate_out_b), .rate_valid(rate_valid_b), .rate_sat(rate_sat_b),
    .isi_out(isi_out_b), .isi_valid(isi_valid_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pops: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rate_valid_a) begin
      compared++;
      if (rate_qa.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL rate_a unexpected: cycle %0d rate_out=%0d, required no pulse", cyc - t0, rate_out_a);
      end else begin
        e_ra = rate_qa.pop_front();
        if ((cyc - t0) !== e_ra.cyc || rate_out_a !== e_ra.val || rate_sat_a !== e_ra.sat) begin
          mismatched++;
          $display("[TB] FAIL rate_a: got cycle %0d rate=%0d sat=%0b, required cycle %0d rate=%0d sat=%0b",
                   cyc - t0, rate_out_a, rate_sat_a, e_ra.cyc, e_ra.val, e_ra.sat);
        end
      end
    end
    if (isi_valid_a) begin
      compared++;
      if (isi_qa.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL isi_a unexpected: cycle %0d isi_out=%0d, required no pulse", cyc - t0, isi_out_a);
      end else begin
        e_ia = isi_qa.pop_front();
        if ((cyc - t0) !== e_ia.cyc || isi_out_a !== e_ia.val) begin
          mismatched++;
          $display("[TB] FAIL isi_a: got cycle %0d isi=%0d, required cycle %0d isi=%0d",
                   cyc - t0, isi_out_a, e_ia.cyc, e_ia.val);
        end
      end
    end
    if (rate_valid_b) begin
      compared++;
      if (rate_qb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL rate_b unexpected: cycle %0d rate_out=%0d, required no pulse", cyc - t0, rate_out_b);
      end else begin
        e_rb = rate_qb.pop_front();
        if ((cyc - t0) !== e_rb.cyc || rate_out_b !== e_rb.val || rate_sat_b !== e_rb.sat) begin
          mismatched++;
          $display("[TB] FAIL rate_b: got cycle %0d rate=%0d sat=%0b, required cycle %0d rate=%0d sat=%0b",
                   cyc - t0, rate_out_b, rate_sat_b, e_rb.cyc, e_rb.val, e_rb.sat);
        end
      end
    end
    if (isi_valid_b) begin
      compared++;
      if (isi_qb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL isi_b unexpected: cycle %0d isi_out=%0d, required no pulse", cyc - t0, isi_out_b);
      end else begin
        e_ib = isi_qb.pop_front();
        if ((cyc - t0) !== e_ib.cyc || isi_out_b !== e_ib.val) begin
          mismatched++;
          $display("[TB] FAIL isi_b: got cycle %0d isi=%0d, required cycle %0d isi=%0d",
                   cyc - t0, isi_out_b, e_ib.cyc, e_ib.val);
        end
      end
    end
  end

  // Holds dut_a in reset for two edges; on return the bench sits in cycle 0 of a fresh window.
  task automatic restart_a();
    rst_a   = 1'b1;
    spike_a = 1'b0;
    clear_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    t0    = cyc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string name);
    compared++;
    if (rate_qa.size() != 0 || isi_qa.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s pending: rate=%0d isi=%0d outstanding, required 0", name, rate_qa.size(), isi_qa.size());
    end
    rate_qa.delete();
    isi_qa.delete();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; spike_a = 1'b1; clear_a = 1'b0;
    rst_b = 1'b1; spike_b = 1'b1; clear_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared += 10;
    if (rate_out_a !== 8'd0)   begin mismatched++; $display("[TB] FAIL reset rate_out_a: got %0d required 0", rate_out_a); end
    if (rate_sat_a !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset rate_sat_a: got %0b required 0", rate_sat_a); end
    if (rate_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset rate_valid_a: got %0b required 0", rate_valid_a); end
    if (isi_out_a !== 8'd0)    begin mismatched++; $display("[TB] FAIL reset isi_out_a: got %0d required 0", isi_out_a); end
    if (isi_valid_a !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset isi_valid_a: got %0b required 0", isi_valid_a); end
    if (rate_out_b !== 8'd0)   begin mismatched++; $display("[TB] FAIL reset rate_out_b: got %0d required 0", rate_out_b); end
    if (rate_sat_b !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset rate_sat_b: got %0b required 0", rate_sat_b); end
    if (rate_valid_b !== 1'b0) begin mismatched++; $display("[TB] FAIL reset rate_valid_b: got %0b required 0", rate_valid_b); end
    if (isi_out_b !== 8'd0)    begin mismatched++; $display("[TB] FAIL reset isi_out_b: got %0d required 0", isi_out_b); end
    if (isi_valid_b !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset isi_valid_b: got %0b required 0", isi_valid_b); end
    spike_b = 1'b0;
  endtask

  // One-cycle pulses every 4 cycles: 4 edges per window, interval 4.
  task automatic test_periodic();
    restart_a();
    for (int w = 1; w <= 4; w++) rate_qa.push_back('{16 * w, 8'd4, 1'b0});
    for (int e = 4; e <= 60; e += 4) isi_qa.push_back('{e + 1, 8'd4, 1'b0});
    for (int k = 0; k < 66; k++) begin
      spike_a = (k < 64) && (k % 4 == 0);
      step();
    end
    drain_a("periodic");
  endtask

  // A level held for 10 cycles is a single edge and yields no interval.
  task automatic test_held_high();
    restart_a();
    rate_qa.push_back('{16, 8'd1, 1'b0});
    for (int k = 0; k < 18; k++) begin
      spike_a = (k >= 2) && (k <= 11);
      step();
    end
    drain_a("held_high");
  endtask

  task automatic test_terminal_edge();
    restart_a();
    rate_qa.push_back('{16, 8'd1, 1'b0});
    rate_qa.push_back('{32, 8'd0, 1'b0});
    for (int k = 0; k < 34; k++) begin
      spike_a = (k == 15);
      step();
    end
    drain_a("terminal_edge");
  endtask

  task automatic test_long_isi();
    restart_a();
    for (int w = 0; w < 20; w++) begin
      rate_qa.push_back('{16 * (w + 1), (w == 0 || w == 19) ? 8'd1 : 8'd0, 1'b0});
    end
    isi_qa.push_back('{306, 8'd255, 1'b0});
    for (int k = 0; k < 322; k++) begin
      spike_a = (k == 5) || (k == 305);
      step();
    end
    drain_a("long_isi");
  endtask

  // Clear with an edge at cycle 3 restarts the window at cycle 4; the edge at 8 is then first.
  task automatic test_clear_edge();
    restart_a();
    rate_qa.push_back('{20, 8'd2, 1'b0});
    isi_qa.push_back('{13, 8'd4, 1'b0});
    for (int k = 0; k < 22; k++) begin
      spike_a = (k == 3) || (k == 8) || (k == 12);
      clear_a = (k == 3);
      step();
    end
    drain_a("clear_edge");
  endtask

  task automatic test_reset_mid_window();
    restart_a();
    isi_qa.push_back('{7, 8'd4, 1'b0});
    for (int k = 0; k < 9; k++) begin
      spike_a = (k == 2) || (k == 6);
      step();
    end
    spike_a = 1'b0;
    rst_a   = 1'b1;
    step();
    compared += 5;
    if (rate_out_a !== 8'd0)   begin mismatched++; $display("[TB] FAIL midreset rate_out_a: got %0d required 0", rate_out_a); end
    if (rate_sat_a !== 1'b0)   begin mismatched++; $display("[TB] FAIL midreset rate_sat_a: got %0b required 0", rate_sat_a); end
    if (rate_valid_a !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset rate_valid_a: got %0b required 0", rate_valid_a); end
    if (isi_out_a !== 8'd0)    begin mismatched++; $display("[TB] FAIL midreset isi_out_a: got %0d required 0", isi_out_a); end
    if (isi_valid_a !== 1'b0)  begin mismatched++; $display("[TB] FAIL midreset isi_valid_a: got %0b required 0", isi_valid_a); end
    drain_a("midreset_isi");
    rst_a = 1'b0;
    t0    = cyc;
    rate_qa.push_back('{16, 8'd1, 1'b0});
    for (int k = 0; k < 18; k++) begin
      spike_a = (k == 1);
      step();
    end
    drain_a("reset_mid_window");
  endtask

  // 1024-cycle window with spike toggling every cycle: 512 edges saturate to 255.
  task automatic test_saturation();
    rst_a   = 1'b1;
    spike_b = 1'b0;
    clear_b = 1'b0;
    step();
    rst_b = 1'b0;
    t0    = cyc;
    rate_qb.push_back('{1024, 8'd255, 1'b1});
    for (int e = 2; e <= 1022; e += 2) isi_qb.push_back('{e + 1, 8'd2, 1'b0});
    for (int k = 0; k < 1026; k++) begin
      spike_b = (k < 1024) && (k % 2 == 0);
      step();
    end
    compared++;
    if (rate_qb.size() != 0 || isi_qb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL saturation pending: rate=%0d isi=%0d outstanding, required 0", rate_qb.size(), isi_qb.size());
    end
    rst_b = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_held_high();
    test_terminal_edge();
    test_long_isi();
    test_clear_edge();
    test_reset_mid_window();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WINDOW_LOG2, default 8, meaning window length = 2**WINDOW_LOG2 cycles (legal range 2..16).
REQ-002 Parameter CNT_W, default 8, meaning width of rate_out and isi_out.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port spike_in  input  1  spike line from a neuron; level signal, may be held high for several cycles.
REQ-006 Port clear  input  1  synchronous restart of window and interval measurement.
REQ-007 Port rate_out  output  CNT_W  rising-edge count of the last completed window, saturating.
REQ-008 Port rate_valid  output  1  one-cycle pulse when rate_out updates.
REQ-009 Port rate_sat  output  1  high when the last completed window's count saturated.
REQ-010 Port isi_out  output  CNT_W  cycles between the two most recent rising edges, saturating.
REQ-011 Port isi_valid  output  1  one-cycle pulse when isi_out updates.

Function
REQ-012 An edge is defined as spike_in=1 in the current cycle with registered spike_d=0; held-high input counts once.
REQ-013 win_cnt (WINDOW_LOG2 bits) increments every cycle, wrapping from 2**WINDOW_LOG2-1 to 0; the terminal cycle is win_cnt = all-ones.
REQ-014 spk_cnt increments by one per edge, saturating at 2**CNT_W-1; it never wraps.
REQ-015 In the terminal cycle, an edge in that same cycle belongs to the closing window.
REQ-016 On the clock edge that ends the terminal cycle, rate_out, rate_sat and rate_valid are registered: rate_out gets the final count, rate_sat=1 iff that count reached 2**CNT_W-1, rate_valid=1.
REQ-017 On that same clock edge, spk_cnt restarts at 0.
REQ-018 rate_out and rate_sat are therefore visible exactly one cycle after the terminal cycle.
REQ-019 isi_cnt loads 1 on an edge; otherwise it increments per cycle, saturating at 2**CNT_W-1.
REQ-020 On an edge with seen=1, isi_out gets the current isi_cnt value and isi_valid pulses the next cycle.
REQ-021 On an edge, seen is set to 1.
REQ-022 On an edge with seen=0 (first edge after reset or clear), isi_out holds and isi_valid stays 0.
REQ-023 Edges at cycles t and t+N give isi_out=min(N, 2**CNT_W-1).
REQ-024 clear=1 sets win_cnt, spk_cnt, isi_cnt and seen to 0.
REQ-025 clear=1 forces rate_valid and isi_valid to 0 the next cycle.
REQ-026 clear=1 leaves rate_out, rate_sat and isi_out holding their values.
REQ-027 clear has priority: an edge, or a terminal cycle, coinciding with clear=1 is discarded.
REQ-028 spike_d still samples spike_in during clear, so a level held high across clear produces no edge after clear.
REQ-029 rate_valid and isi_valid are never high for two consecutive cycles.

Reset
REQ-030 rst=1 sets all state registers and outputs to 0 (including spike_d, seen, win_cnt), with priority over clear and edges.
REQ-031 After rst is released, the first window is full-length, starting at win_cnt=0.
REQ-032 After rst is released, the first edge produces no isi_valid.
REQ-033 Reset mid-window discards the partial count.

Structure
REQ-034 Shared package spike_pkg holds CNT_W default and the saturation-limit constant, for reuse by the neuron and decoder blocks.
REQ-035 One sub-module, sat_counter (parameterised width, inc/load/clear, saturating), is instantiated for both spk_cnt and isi_cnt.
REQ-036 All outputs are driven directly from registers; there is no combinational path from spike_in to any output.

Verification (WINDOW_LOG2=4 unless stated)
REQ-037 Bench covers: 1-cycle pulses every 4 cycles from reset -> every rate_valid shows rate_out=4, rate_sat=0; every isi_valid after the first edge shows isi_out=4.
REQ-038 Bench covers: spike_in held high 10 cycles inside one window -> rate_out=1 for that window, no isi_valid.
REQ-039 Bench covers: WINDOW_LOG2=10, spike_in toggling every cycle -> 512 edges per window -> rate_out=255, rate_sat=1.
REQ-040 Bench covers: two edges 300 cycles apart -> isi_out=255, isi_valid one pulse.
REQ-041 Bench covers: single edge in terminal cycle (win_cnt=15) -> closing window reports rate_out=1, next window reports 0.
REQ-042 Bench covers: clear asserted on the same cycle as an edge -> edge not counted and next edge gives no isi_valid.
REQ-043 Bench covers: rst asserted mid-window -> all outputs 0 the next cycle, and the first rate_valid arrives exactly 16 cycles after release.
